fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4; number of instruction entries, power of two, 2..16.
REQ-002 SHALL provide parameter RESET_PC, default 32'h00001000; fetch address loaded at reset.
REQ-003 SHALL have port clk, input, 1; the single clock, with all state updated on the rising edge.
REQ-004 SHALL have port rst, input, 1; synchronous active-high reset.
REQ-005 SHALL have port icReqAddr, output, 32; fetch address to instruction cache, always word-aligned.
REQ-006 SHALL have port icReqValid, output, 1; fetch request active.
REQ-007 SHALL have port icRespValid, input, 1; cache returns data for icReqAddr this cycle.
REQ-008 SHALL have port icRespData, input, 32; instruction word.
REQ-009 SHALL have port redirectValid, input, 1; branch/jump redirect from execute.
REQ-010 SHALL have port redirectPc, input, 32; redirect target.
REQ-011 SHALL have port decReady, input, 1; decode stage accepts the head entry.
REQ-012 SHALL have port decValid, output, 1; head entry valid.
REQ-013 SHALL have port decInst, output, 32; head instruction.
REQ-014 SHALL have port decPc, output, 32; address of the head instruction.
REQ-015 SHALL have port queueCount, output, log2(DEPTH)+1; number of occupied entries.

Function
REQ-016 SHALL hold a fetch PC register driving icReqAddr, with bits [1:0] always 0.
REQ-017 SHALL assert icReqValid exactly when not in reset and queueCount < DEPTH; it SHALL have no combinational dependence on decReady.
REQ-018 SHALL treat a cycle with icReqValid && icRespValid as a transfer: {PC, icRespData} is written at the tail and PC advances by 4 (modulo 2^32).
REQ-019 SHALL hold icReqAddr stable while icReqValid is high and no transfer or redirect occurs; multi-cycle cache latency SHALL be tolerated.
REQ-020 SHALL implement the queue as a DEPTH-entry circular buffer with head/tail pointers wrapping from DEPTH-1 to 0.
REQ-021 SHALL drive decValid = (queueCount != 0), decInst/decPc = head entry, and decInst/decPc = 0 when empty.
REQ-022 SHALL pop the head on decValid && decReady; decReady with an empty queue SHALL have no effect.
REQ-023 SHALL have a push-to-decValid latency of 1 cycle when the bypass is absent (written entry visible the cycle after the transfer).
REQ-024 SHALL perform a push and a pop in the same cycle with queueCount unchanged, including at queueCount = DEPTH-1.
REQ-025 SHALL, when full, allow no push; a pop in that cycle SHALL re-enable icReqValid in the next cycle.
REQ-026 SHALL, on redirectValid, flush all entries (queueCount <= 0, head = tail), discard any same-cycle transfer, and load PC <= {redirectPc[31:2], 2'b00}.
REQ-027 SHALL give redirectValid priority over transfer and pop in the same cycle; no pop is reported to decode.
REQ-028 SHALL let the cache abandon an in-progress request whose address changes due to redirect.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set PC <= RESET_PC, pointers <= 0 and queueCount <= 0.
REQ-030 SHALL hold decValid = 0, decInst = 0, decPc = 0 and icReqValid = 0 while rst is high.
REQ-031 SHALL give rst priority over redirectValid, transfer and pop; reset mid-request SHALL drop the request.

Configuration
REQ-032 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined, drive decValid = 1, decInst = icRespData and decPc = PC combinationally in a cycle where the queue is empty and a transfer occurs; if decReady is also high the entry is not written, otherwise it is written normally.
REQ-033 SHALL, with FETCH_QUEUE_BYPASS_EN undefined, make all decode outputs purely registered-state driven with the 1-cycle latency of REQ-023.

Verification
REQ-034 SHALL cover the following: release reset, icRespValid = 1 constantly, decReady = 1 -> icReqAddr 0x1000, 0x1004, 0x1008 on consecutive cycles; decPc follows 1 cycle later (same cycle with bypass).
REQ-035 SHALL cover the following: decReady = 0, icRespValid = 1, DEPTH = 4 -> after 4 transfers queueCount = 4, icReqValid = 0, icReqAddr = 0x1010 held.
REQ-036 SHALL cover the following: full queue, assert decReady for 1 cycle -> decPc 0x1000 popped, queueCount 3, next cycle transfer of 0x1010.
REQ-037 SHALL cover the following: icRespValid low for 3 cycles during a request at 0x1008 -> icReqAddr stable at 0x1008, no push, then a single push on response.
REQ-038 SHALL cover the following: queueCount = 2 with redirectValid = 1, redirectPc = 0x2003 and same-cycle transfer -> next cycle queueCount = 0, decValid = 0, icReqAddr = 0x2000.
REQ-039 SHALL cover the following: rst asserted while queueCount = 3 and a request is pending -> next cycle queueCount = 0, icReqAddr = 0x1000, decValid = 0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch PC generator plus a DEPTH-entry circular
// buffer of {pc, instruction} pairs feeding decode.
// Optional feature macro: FETCH_QUEUE_BYPASS_EN. When it is defined, a response
// that arrives while the queue is empty goes straight to decode in the same
// cycle. When it is undefined, the decode outputs come only from registered state.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h00001000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              icReqAddr,
    output logic                     icReqValid,
    input  logic                     icRespValid,
    input  logic [31:0]              icRespData,
    input  logic                     redirectValid,
    input  logic [31:0]              redirectPc,
    input  logic                     decReady,
    output logic                     decValid,
    output logic [31:0]              decInst,
    output logic [31:0]              decPc,
    output logic [$clog2(DEPTH):0]   queueCount
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [31:0]   PC_INIT = RESET_PC & ~32'h3;

    typedef logic [AW-1:0] ptr_t;

    logic [31:0] pc_q, pc_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [AW:0] count_q, count_d;

    // Entry storage. No reset: an entry is only read after it has been written.
    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic empty;
    logic full;
    logic xfer;      // request and response in the same cycle
    logic byp;       // response goes straight to decode (bypass build only)
    logic byp_take;  // decode accepts the bypassed word, so it is not stored
    logic pop;       // head entry leaves the queue
    logic push;      // fetched word is written at the tail

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A request depends only on occupancy, so decReady has no combinational path to it.
    assign icReqValid = !rst && !full;
    assign icReqAddr  = pc_q;
    assign queueCount = count_q;
    assign xfer       = icReqValid && icRespValid;

`ifdef FETCH_QUEUE_BYPASS_EN
    // A redirect discards the fetched word, so it must not reach decode either.
    assign byp      = empty && xfer && !redirectValid;
    assign byp_take = byp && decReady;
`else
    assign byp      = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign pop  = !rst && !empty && decReady && !redirectValid;
    assign push = xfer && !redirectValid && !byp_take;

    // Decode view: the head entry, or the bypassed word, or zeros.
    always_comb begin
        decValid = 1'b0;
        decInst  = '0;
        decPc    = '0;
        if (!rst) begin
            if (!empty) begin
                decValid = 1'b1;
                decInst  = inst_mem_q[head_q];
                decPc    = pc_mem_q[head_q];
            end else if (byp) begin
                decValid = 1'b1;
                decInst  = icRespData;
                decPc    = pc_q;
            end
        end
    end

    // Next-state values for the PC, the pointers and the occupancy count.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (redirectValid) begin
            pc_d    = redirectPc & ~32'h3;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (xfer) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                tail_d = tail_q + ptr_t'(1);
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // State registers. Reset has priority over redirect, transfer and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= PC_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Write the fetched word and its address at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= icRespData;
            pc_mem_q[tail_q]   <= pc_q;
        end
    end

endmodule
